// File: rtl/mem_stage_sram_pkg.sv
// Shared definitions for the MEM stage: FSM state encoding and default parameters.
package mem_stage_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [31:0] DATA_BASE_DEFAULT   = 32'd1024;
  localparam int          SRAM_ADDR_W_DEFAULT = 18;
  localparam int          WAIT_CYCLES_DEFAULT = 2;

endpackage

// File: rtl/mem_stage_sram_mem_wb_reg.sv
// MEM/WB pipeline register; a frozen cycle inserts a bubble and holds the data fields.
module mem_wb_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] mem_data_in,
  input  logic [3:0]  dest_in,
  output logic        wb_en_out,
  output logic        mem_r_en_out,
  output logic [31:0] alu_res_out,
  output logic [31:0] mem_data_out,
  output logic [3:0]  dest_out
);

  logic        wb_en_q, wb_en_d;
  logic        mem_r_en_q, mem_r_en_d;
  logic [31:0] alu_res_q, alu_res_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic [3:0]  dest_q, dest_d;

  always_comb begin
    wb_en_d    = 1'b0;
    mem_r_en_d = 1'b0;
    alu_res_d  = alu_res_q;
    mem_data_d = mem_data_q;
    dest_d     = dest_q;
    if (!freeze) begin
      wb_en_d    = wb_en_in;
      mem_r_en_d = mem_r_en_in;
      alu_res_d  = alu_res_in;
      mem_data_d = mem_data_in;
      dest_d     = dest_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      alu_res_q  <= '0;
      mem_data_q <= '0;
      dest_q     <= '0;
    end else begin
      wb_en_q    <= wb_en_d;
      mem_r_en_q <= mem_r_en_d;
      alu_res_q  <= alu_res_d;
      mem_data_q <= mem_data_d;
      dest_q     <= dest_d;
    end
  end

  assign wb_en_out    = wb_en_q;
  assign mem_r_en_out = mem_r_en_q;
  assign alu_res_out  = alu_res_q;
  assign mem_data_out = mem_data_q;
  assign dest_out     = dest_q;

endmodule

// File: rtl/mem_stage_sram.sv
// MEM stage: 32-bit LDR/STR over a 16-bit SRAM as two half-word phases, stalling upstream via freeze.
module mem_stage_sram
  import mem_stage_sram_pkg::*;
#(
  parameter int          SRAM_ADDR_W = SRAM_ADDR_W_DEFAULT,
  parameter logic [31:0] DATA_BASE   = DATA_BASE_DEFAULT,
  parameter int          WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_en_in,
  input  logic                   mem_r_en_in,
  input  logic                   mem_w_en_in,
  input  logic [31:0]            alu_res_in,
  input  logic [31:0]            val_rm_in,
  input  logic [3:0]             dest_in,
  output logic                   freeze,
  output logic                   wb_en_out,
  output logic                   mem_r_en_out,
  output logic [31:0]            alu_res_out,
  output logic [31:0]            mem_data_out,
  output logic [3:0]             dest_out,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rd_q, rd_d;
  logic        req, is_write, last, in_xfer, drive;
  logic [31:0] off;
  logic [30:0] half;
  logic [31:0] load_word;
  logic        unused_bits;

  always_comb begin
    req       = mem_r_en_in | mem_w_en_in;
    is_write  = mem_w_en_in;
    last      = (cnt_q == LAST_CNT);
    in_xfer   = (state_q == ST_LO) || (state_q == ST_HI);
    drive     = in_xfer & is_write;
    freeze    = rst & req & (state_q != ST_DONE);
    // Word offset from the data base; the half select comes from the phase.
    off       = alu_res_in - DATA_BASE;
    half      = {off[31:2], state_q == ST_HI};
    load_word = (mem_r_en_in & ~mem_w_en_in) ? rd_q : 32'h0;
  end

  assign unused_bits = ^{off[1:0], half[30:SRAM_ADDR_W]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_LO;
          cnt_d   = 4'd0;
        end
      end
      ST_LO: begin
        if (last) begin
          state_d = ST_HI;
          cnt_d   = 4'd0;
          if (!is_write) rd_d[15:0] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_HI: begin
        if (last) begin
          state_d = ST_DONE;
          cnt_d   = 4'd0;
          if (!is_write) rd_d[31:16] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rd_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

  // Pad outputs are idle (address 0, bus released) whenever no phase is active.
  always_comb begin
    sram_addr   = in_xfer ? half[SRAM_ADDR_W-1:0] : '0;
    sram_we_n   = ~drive;
    sram_dq_oe  = drive;
    sram_dq_out = 16'h0;
    if (drive) sram_dq_out = (state_q == ST_HI) ? val_rm_in[31:16] : val_rm_in[15:0];
  end

  mem_wb_reg u_mem_wb_reg (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .wb_en_in     (wb_en_in),
    .mem_r_en_in  (mem_r_en_in),
    .alu_res_in   (alu_res_in),
    .mem_data_in  (load_word),
    .dest_in      (dest_in),
    .wb_en_out    (wb_en_out),
    .mem_r_en_out (mem_r_en_out),
    .alu_res_out  (alu_res_out),
    .mem_data_out (mem_data_out),
    .dest_out     (dest_out)
  );

endmodule

// File: tb/tb_mem_stage_sram.sv
// Randomized bench for mem_stage_sram with an SRAM pad model and a transaction-level reference.
module tb_mem_stage_sram;

  localparam int AW = 18;
  localparam int WC = 2;
  localparam int MEM_OP_STALL = 1 + 2 * WC;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [31:0]   alu_res_in, val_rm_in;
  logic [3:0]    dest_in;
  logic          freeze, wb_en_out, mem_r_en_out;
  logic [31:0]   alu_res_out, mem_data_out;
  logic [3:0]    dest_out;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out, sram_dq_in;
  logic          sram_dq_oe, sram_we_n;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [15:0] ref_mem [int];

  // SRAM pad model with a bench-only preload port
  logic [15:0]   sram_mem [0:(1<<AW)-1];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [15:0]   pre_data = '0;

  assign sram_dq_in = sram_mem[sram_addr];
  always @(posedge clk) begin
    if (pre_we) sram_mem[pre_addr] <= pre_data;
    else if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr] <= sram_dq_out;
  end

  always #5 clk = ~clk;

  mem_stage_sram #(.SRAM_ADDR_W(AW), .DATA_BASE(32'd1024), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .alu_res_in(alu_res_in), .val_rm_in(val_rm_in), .dest_in(dest_in),
    .freeze(freeze), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .alu_res_out(alu_res_out), .mem_data_out(mem_data_out), .dest_out(dest_out),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Half-word index: ((byte - 1024) mod 2^32) / 4 words, two halves per word, mod 2^AW.
  function automatic int ref_half(input logic [31:0] byte_addr, input int hi);
    longint off;
    off = (longint'({32'h0, byte_addr}) + 64'h1_0000_0000 - 1024) % 64'h1_0000_0000;
    return int'(((off / 4) * 2 + hi) % (64'd1 << AW));
  endfunction

  function automatic logic [15:0] ref_rd(input int idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : 16'h0;
  endfunction

  function automatic logic [31:0] pick_addr(input int k);
    case (k)
      16:      return 32'h0000_0000;
      17:      return 32'h0000_0004;
      18:      return 32'hFFFF_FFF0;
      19:      return 32'd1000;
      default: return 32'd1024 + 32'(4 * k) + 32'($urandom_range(0, 3));
    endcase
  endfunction

  task automatic idle_inputs();
    wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0;
    alu_res_in = 0; val_rm_in = 0; dest_in = 0;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic do_op(input logic wb, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] v, input logic [3:0] d);
    int stalls, wen, lo, hi;
    lo = ref_half(a, 0);
    hi = ref_half(a, 1);
    exp_q.push_back((r && !w) ? {ref_rd(hi), ref_rd(lo)} : 32'h0);
    wb_en_in = wb; mem_r_en_in = r; mem_w_en_in = w;
    alu_res_in = a; val_rm_in = v; dest_in = d;
    #1;
    stalls = 0;
    wen = 0;
    while (freeze && stalls < 40) begin
      if (stalls > 0) begin
        check("bubble_wb_en", 32'(wb_en_out), 32'h0);
        check("bubble_mem_r_en", 32'(mem_r_en_out), 32'h0);
      end
      if (!sram_we_n) wen++;
      stalls++;
      @(negedge clk); #1;
    end
    if (!sram_we_n) wen++;
    check("stall_cycles", 32'(stalls), (r || w) ? 32'(MEM_OP_STALL) : 32'h0);
    check("we_n_low_cycles", 32'(wen), w ? 32'(2 * WC) : 32'h0);
    @(negedge clk); #1;
    check("wb_en_out", 32'(wb_en_out), 32'(wb));
    check("mem_r_en_out", 32'(mem_r_en_out), 32'(r));
    check("alu_res_out", alu_res_out, a);
    check("dest_out", 32'(dest_out), 32'(d));
    check("mem_data_out", mem_data_out, exp_q.pop_front());
    if (w) begin
      ref_mem[lo] = v[15:0];
      ref_mem[hi] = v[31:16];
      check("sram_lo_half", 32'(sram_mem[lo]), 32'(ref_mem[lo]));
      check("sram_hi_half", 32'(sram_mem[hi]), 32'(ref_mem[hi]));
    end
  endtask

  initial begin
    int kind, k;
    logic [31:0] a;
    rst = 1'b0;
    idle_inputs();
    // Preload the data window while reset is held.
    for (int kk = 0; kk < 16; kk++) begin
      for (int h = 0; h < 2; h++) begin
        @(negedge clk);
        pre_addr = AW'(ref_half(32'd1024 + 32'(4 * kk), h));
        pre_data = 16'($urandom);
        ref_mem[ref_half(32'd1024 + 32'(4 * kk), h)] = pre_data;
        pre_we = 1'b1;
      end
    end
    @(negedge clk);
    pre_we = 1'b0;
    @(negedge clk); #1;
    check("rst_freeze", 32'(freeze), 32'h0);
    check("rst_wb_en_out", 32'(wb_en_out), 32'h0);
    check("rst_alu_res_out", alu_res_out, 32'h0);
    check("rst_mem_data_out", mem_data_out, 32'h0);
    check("rst_sram_we_n", 32'(sram_we_n), 32'h1);
    check("rst_sram_addr", 32'(sram_addr), 32'h0);
    mem_w_en_in = 1'b1;
    #1;
    check("rst_forces_freeze_low", 32'(freeze), 32'h0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    #1;

    // Directed: ALU op, STR, LDR of the same word, back-to-back LDR/STR, both enables.
    do_op(1, 0, 0, 32'h55, 32'h0, 4'd3);
    do_op(0, 0, 1, 32'd1028, 32'hDEADBEEF, 4'd4);
    check("str_addr2_beef", 32'(sram_mem[2]), 32'h0000BEEF);
    check("str_addr3_dead", 32'(sram_mem[3]), 32'h0000DEAD);
    do_op(1, 1, 0, 32'd1028, 32'h0, 4'd5);
    do_op(1, 1, 0, 32'd1032, 32'h0, 4'd6);
    do_op(0, 0, 1, 32'd1036, 32'h12345678, 4'd7);
    do_op(1, 1, 1, 32'd1040, 32'hCAFEF00D, 4'd8);
    do_op(1, 1, 0, 32'd1040, 32'h0, 4'd9);

    // Random mix of ALU ops, loads, stores and dual-enable stores.
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      k = $urandom_range(0, 19);
      a = pick_addr(k);
      if (kind == 1 && !ref_mem.exists(ref_half(a, 0))) kind = 2;
      do_op(1'($urandom_range(0, 1)), kind == 1 || kind == 3, kind >= 2,
            (kind == 0) ? 32'($urandom) : a, 32'($urandom), 4'($urandom_range(0, 15)));
    end

    // Reset during the HI phase of a store to an address that is never read back.
    wb_en_in = 1; mem_w_en_in = 1; alu_res_in = 32'd1024 + 32'd800;
    val_rm_in = 32'hA5A5_5A5A; dest_in = 4'd2;
    for (int c = 0; c < 1 + WC; c++) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    check("hi_rst_freeze", 32'(freeze), 32'h0);
    check("hi_rst_we_n", 32'(sram_we_n), 32'h1);
    check("hi_rst_oe", 32'(sram_dq_oe), 32'h0);
    check("hi_rst_sram_addr", 32'(sram_addr), 32'h0);
    check("hi_rst_dq_out", 32'(sram_dq_out), 32'h0);
    check("hi_rst_outputs", {wb_en_out, mem_r_en_out, dest_out}, 32'h0);
    check("hi_rst_alu_res", alu_res_out, 32'h0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    #1;
    do_op(1, 1, 0, 32'd1036, 32'h0, 4'd1);
    do_op(1, 0, 0, 32'h77, 32'h0, 4'd2);

    idle_inputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
